// File: rtl/ascon_pkg.sv
// Shared types and defaults for the ascon core arbiter/sequencer.
package ascon_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_START,
        ARB_GAP,
        ARB_FETCH,
        ARB_ISSUE,
        ARB_WAIT_CIPHER,
        ARB_WAIT_DONE
    } t_arb_state;

    localparam int unsigned WORDS_PER_MSG = 4;
    localparam int unsigned ARB_START_GAP = 14;
    localparam int unsigned ARB_WORD_GAP  = 8;

endpackage

// File: rtl/ascon_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant_i, cyclically.
module rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    last_grant_i,
    output logic [N_REQ-1:0] grant_o,
    output logic             any_o
);

    logic [IW-1:0] idx;

    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        idx     = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = IW'((32'(last_grant_i) + k) % N_REQ);
            if (!any_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                any_o        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ascon_arbiter.sv
// Shares one ascon core between N_REQ requesters: grants per message, paces the
// core strobes and routes cipher words and the tag back to the granted requester.
module ascon_arbiter
    import ascon_pkg::*;
#(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned START_GAP = ARB_START_GAP,
    parameter int unsigned WORD_GAP  = ARB_WORD_GAP
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    i_sys_enable,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ-1:0][127:0] i_key,
    input  logic [N_REQ-1:0][127:0] i_nonce,
    input  logic [N_REQ-1:0]        i_word_valid,
    input  logic [N_REQ-1:0][63:0]  i_word,
    output logic [N_REQ-1:0]        o_word_ready,
    output logic [N_REQ-1:0]        o_grant,
    output logic [63:0]             o_cipher,
    output logic [N_REQ-1:0]        o_cipher_valid,
    output logic [127:0]            o_tag,
    output logic [N_REQ-1:0]        o_done,
    output logic                    o_core_start,
    output logic                    o_core_data_valid,
    output logic [63:0]             o_core_data,
    output logic [127:0]            o_core_key,
    output logic [127:0]            o_core_nonce,
    input  logic [63:0]             i_core_cipher,
    input  logic                    i_core_valid_cipher,
    input  logic [127:0]            i_core_tag,
    input  logic                    i_core_done
);

    localparam int unsigned IW         = $clog2(N_REQ);
    localparam logic [4:0]  START_LOAD = 5'(START_GAP - 1);
    localparam logic [4:0]  WORD_LOAD  = 5'(WORD_GAP - 1);

    t_arb_state        state_q, state_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [IW-1:0]     last_q, last_d;
    logic [4:0]        gap_q, gap_d;
    logic [2:0]        widx_q, widx_d;
    logic [63:0]       data_q, data_d;
    logic [63:0]       cipher_q, cipher_d;
    logic [N_REQ-1:0]  cvalid_q, cvalid_d;
    logic [127:0]      tag_q, tag_d;
    logic [N_REQ-1:0]  done_q, done_d;

    logic [N_REQ-1:0]  pick_oh;
    logic              pick_any;
    logic [IW-1:0]     pick_idx;
    logic [N_REQ-1:0]  grant_oh;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr (
        .req_i        (i_req),
        .last_grant_i (last_q),
        .grant_o      (pick_oh),
        .any_o        (pick_any)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_oh[i]) pick_idx = IW'(i);
        end
    end

    assign grant_oh = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        gap_d    = gap_q;
        widx_d   = widx_q;
        data_d   = data_q;
        cipher_d = cipher_q;
        cvalid_d = '0;
        tag_d    = tag_q;
        done_d   = '0;
        case (state_q)
            ARB_IDLE: begin
                // Hold off while o_done is pulsing so the finishing requester can drop i_req.
                if (pick_any && done_q == '0) begin
                    grant_d = pick_idx;
                    widx_d  = '0;
                    state_d = ARB_START;
                end
            end
            ARB_START: begin
                gap_d   = START_LOAD;
                state_d = (START_LOAD == 5'd0) ? ARB_FETCH : ARB_GAP;
            end
            ARB_GAP: begin
                gap_d = gap_q - 5'd1;
                if (gap_q <= 5'd1) state_d = ARB_FETCH;
            end
            ARB_FETCH: begin
                if (!i_req[grant_q]) begin
                    last_d  = grant_q;
                    state_d = ARB_IDLE;
                end else if (i_word_valid[grant_q]) begin
                    data_d  = i_word[grant_q];
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                widx_d = widx_q + 3'd1;
                if (widx_q == 3'd0) begin
                    gap_d   = WORD_LOAD;
                    state_d = (WORD_LOAD == 5'd0) ? ARB_FETCH : ARB_GAP;
                end else begin
                    state_d = ARB_WAIT_CIPHER;
                end
            end
            ARB_WAIT_CIPHER: begin
                if (i_core_valid_cipher) begin
                    cipher_d = i_core_cipher;
                    cvalid_d = grant_oh;
                    state_d  = (widx_q == 3'(WORDS_PER_MSG)) ? ARB_WAIT_DONE : ARB_FETCH;
                end
            end
            ARB_WAIT_DONE: begin
                if (i_core_done) begin
                    tag_d   = i_core_tag;
                    done_d  = grant_oh;
                    last_d  = grant_q;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            last_q   <= IW'(N_REQ - 1);
            gap_q    <= '0;
            widx_q   <= '0;
            data_q   <= '0;
            cipher_q <= '0;
            cvalid_q <= '0;
            tag_q    <= '0;
            done_q   <= '0;
        end else if (i_sys_enable) begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            gap_q    <= gap_d;
            widx_q   <= widx_d;
            data_q   <= data_d;
            cipher_q <= cipher_d;
            cvalid_q <= cvalid_d;
            tag_q    <= tag_d;
            done_q   <= done_d;
        end
    end

    assign o_grant           = (state_q != ARB_IDLE) ? grant_oh : '0;
    assign o_word_ready      = (state_q == ARB_FETCH) ? (grant_oh & i_req) : '0;
    assign o_core_start      = (state_q == ARB_START);
    assign o_core_data_valid = (state_q == ARB_ISSUE);
    assign o_core_data       = data_q;
    assign o_core_key        = i_key[grant_q];
    assign o_core_nonce      = i_nonce[grant_q];
    assign o_cipher          = cipher_q;
    assign o_cipher_valid    = cvalid_q;
    assign o_tag             = tag_q;
    assign o_done            = done_q;

endmodule

// File: tb/tb_ascon_arbiter.sv
// Scoreboard bench for ascon_arbiter with a behavioural core stub.
module tb_ascon_arbiter;

    localparam logic [63:0] CMIX = 64'hA5A5_5A5A_0F0F_F0F0;

    typedef struct {
        logic         is_tag;
        logic [1:0]   who;
        logic [127:0] val;
    } sb_t;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              sys_en;
    logic [1:0]        req, wvalid;
    logic [1:0][127:0] key, nonce;
    logic [1:0][63:0]  word;
    logic [1:0]        o_word_ready, o_grant, o_cipher_valid, o_done;
    logic [63:0]       o_cipher, o_core_data;
    logic [127:0]      o_tag, o_core_key, o_core_nonce;
    logic              o_core_start, o_core_data_valid;
    logic [63:0]       core_cipher;
    logic              core_valid;
    logic [127:0]      core_tag;
    logic              core_done;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_start = 0, n_dv = 0, n_cv0 = 0, n_done = 0;
    int   exp_gap = 14;
    int   stray_cnt = 0;
    sb_t  sb[$];
    logic [1:0] exp_start[$];

    always #5 clock = ~clock;

    ascon_arbiter #(
        .N_REQ     (2),
        .START_GAP (14),
        .WORD_GAP  (8)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .i_sys_enable        (sys_en),
        .i_req               (req),
        .i_key               (key),
        .i_nonce             (nonce),
        .i_word_valid        (wvalid),
        .i_word              (word),
        .o_word_ready        (o_word_ready),
        .o_grant             (o_grant),
        .o_cipher            (o_cipher),
        .o_cipher_valid      (o_cipher_valid),
        .o_tag               (o_tag),
        .o_done              (o_done),
        .o_core_start        (o_core_start),
        .o_core_data_valid   (o_core_data_valid),
        .o_core_data         (o_core_data),
        .o_core_key          (o_core_key),
        .o_core_nonce        (o_core_nonce),
        .i_core_cipher       (core_cipher),
        .i_core_valid_cipher (core_valid),
        .i_core_tag          (core_tag),
        .i_core_done         (core_done)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Core stub: cipher 2 cycles after each plaintext issue, tag 3 cycles after the last cipher.
    initial begin : core_model
        int nw = 0, cd_c = 0, cd_d = 0, seen = 0;
        logic [63:0] pend = '0;
        core_valid = 1'b0; core_done = 1'b0; core_cipher = '0; core_tag = '0;
        forever begin
            @(posedge clock); #1;
            core_valid = 1'b0;
            core_done  = 1'b0;
            if (cd_d > 0) begin
                cd_d--;
                if (cd_d == 0) begin
                    core_done = 1'b1;
                    core_tag  = o_core_key ^ {o_core_nonce[63:0], o_core_nonce[127:64]};
                end
            end
            if (cd_c > 0) begin
                cd_c--;
                if (cd_c == 0) begin
                    core_valid  = 1'b1;
                    core_cipher = pend;
                    if (nw == 4) cd_d = 3;
                end
            end
            if (stray_cnt != seen) begin
                seen      = stray_cnt;
                core_done = 1'b1;
                core_tag  = '1;
            end
            if (o_core_start && sys_en) nw = 0;
            if (o_core_data_valid && sys_en) begin
                if (nw > 0) begin
                    cd_c = 2;
                    pend = o_core_data ^ o_core_key[63:0] ^ CMIX;
                end
                nw++;
            end
        end
    end

    initial begin : monitor
        int start_cyc = 0;
        bit gap_pend = 0;
        logic [1:0] cur_grant = '0;
        sb_t it;
        forever begin
            @(negedge clock);
            cyc++;
            if (o_core_start) begin
                n_start++;
                if (exp_start.size() == 0) check("start_unexp", o_grant, 2'b00);
                else begin
                    cur_grant = exp_start.pop_front();
                    check("start_grant", o_grant, cur_grant);
                end
                start_cyc = cyc;
                gap_pend  = 1;
            end
            if (gap_pend && |o_word_ready) begin
                check("start_gap", 128'(cyc - start_cyc), 128'(exp_gap));
                gap_pend = 0;
            end
            if (o_grant != 2'b00) check("grant_hold", o_grant, cur_grant);
            if (o_core_data_valid) n_dv++;
            if (o_cipher_valid[0]) n_cv0++;
            if (|o_cipher_valid) begin
                if (sb.size() == 0) check("cv_unexp", o_cipher_valid, 2'b00);
                else begin
                    it = sb.pop_front();
                    check("cv_kind", it.is_tag, 1'b0);
                    check("cv_who", o_cipher_valid, it.who);
                    check("cv_data", o_cipher, it.val);
                end
            end
            if (|o_done) begin
                n_done++;
                if (sb.size() == 0) check("done_unexp", o_done, 2'b00);
                else begin
                    it = sb.pop_front();
                    check("done_kind", it.is_tag, 1'b1);
                    check("done_who", o_done, it.who);
                    check("done_tag", o_tag, it.val);
                end
            end
        end
    end

    task automatic check_reset_outs(input string tag);
        check({tag, "_ctl"}, {o_grant, o_word_ready, o_cipher_valid, o_done, o_core_start, o_core_data_valid}, '0);
        check({tag, "_data"}, {o_cipher, o_core_data}, '0);
        check({tag, "_tag"}, o_tag, '0);
    endtask

    task automatic run_msg(input int r, input logic [63:0] base, input int stall_w,
                           input int abort_w, input int reset_w, input bit chk_lat);
        int budget;
        int n0;
        logic [1:0] oh;
        sb_t it;
        oh = '0;
        oh[r] = 1'b1;
        wvalid[r] = 1'b0;
        req[r] = 1'b1;
        if (chk_lat) begin
            @(posedge clock); #1;
            check("start_lat", o_core_start, 1'b1);
        end
        for (int w = 0; w < 4; w++) begin
            word[r]   = base + 64'(w);
            wvalid[r] = (w != stall_w);
            budget = 0;
            while (!o_word_ready[r] && budget < 1000) begin
                @(posedge clock); #1;
                budget++;
            end
            if (!o_word_ready[r]) begin
                check("ready_timeout", 1'b0, 1'b1);
                req[r] = 1'b0; wvalid[r] = 1'b0;
                return;
            end
            if (w == abort_w) begin
                req[r] = 1'b0; wvalid[r] = 1'b0;
                @(posedge clock); #1;
                check("abort_idle", o_grant, 2'b00);
                return;
            end
            if (w == stall_w) begin
                n0 = n_dv;
                repeat (20) begin @(posedge clock); #1; end
                check("bp_nodv", 128'(n_dv - n0), '0);
                check("bp_ready", o_word_ready[r], 1'b1);
                wvalid[r] = 1'b1;
            end
            if (w > 0) begin
                it.is_tag = 1'b0; it.who = oh;
                it.val = 128'((base + 64'(w)) ^ key[r][63:0] ^ CMIX);
                sb.push_back(it);
            end
            if (w == 3) begin
                it.is_tag = 1'b1; it.who = oh;
                it.val = key[r] ^ {nonce[r][63:0], nonce[r][127:64]};
                sb.push_back(it);
            end
            @(posedge clock); #1;
            wvalid[r] = 1'b0;
            check("issue_dv", o_core_data_valid, 1'b1);
            check("issue_data", o_core_data, base + 64'(w));
            if (w == reset_w) begin
                @(posedge clock); #1;
                reset_n = 1'b0;
                sb.delete();
                #1;
                check_reset_outs("rst_mid");
                @(posedge clock); #1;
                reset_n = 1'b1;
                req[r] = 1'b0;
                return;
            end
        end
        budget = 0;
        while (!o_done[r] && budget < 1000) begin
            @(posedge clock); #1;
            budget++;
        end
        if (!o_done[r]) check("done_timeout", 1'b0, 1'b1);
        req[r] = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        check("watchdog", 1'b0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int s0, d0, c0, e0;
        reset_n = 1'b0; sys_en = 1'b1;
        req = '0; wvalid = '0; word = '0;
        key[0]   = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        key[1]   = 128'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F;
        nonce[0] = 128'h1357_9BDF_0246_8ACE_FDB9_7531_ECA8_6420;
        nonce[1] = 128'hDEAD_BEEF_CAFE_F00D_0BAD_C0DE_1234_5678;
        #1;
        check_reset_outs("rst_init");
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        e0 = n_done;
        stray_cnt++;
        repeat (5) begin @(posedge clock); #1; end
        check("stray_done", 128'(n_done - e0), '0);
        check("stray_tag", o_tag, '0);
        check("stray_grant", o_grant, 2'b00);

        s0 = n_start; d0 = n_dv; c0 = n_cv0; e0 = n_done;
        exp_start.push_back(2'b01);
        run_msg(0, 64'hA, -1, -1, -1, 1'b1);
        repeat (3) begin @(posedge clock); #1; end
        check("single_starts", 128'(n_start - s0), 128'd1);
        check("single_dv", 128'(n_dv - d0), 128'd4);
        check("single_cv0", 128'(n_cv0 - c0), 128'd3);
        check("single_done", 128'(n_done - e0), 128'd1);

        exp_start.push_back(2'b01);
        run_msg(0, 64'h5000, 1, -1, -1, 1'b0);
        repeat (3) begin @(posedge clock); #1; end

        exp_gap = 19;
        exp_start.push_back(2'b01);
        fork
            run_msg(0, 64'h7700, -1, -1, -1, 1'b0);
            begin
                int b = 0;
                while (!o_core_start && b < 100) begin @(posedge clock); #1; b++; end
                repeat (5) begin @(posedge clock); #1; end
                sys_en = 1'b0;
                repeat (5) begin @(posedge clock); #1; end
                sys_en = 1'b1;
            end
        join
        exp_gap = 14;
        repeat (3) begin @(posedge clock); #1; end

        exp_start.push_back(2'b01);
        run_msg(0, 64'h9900, -1, -1, 1, 1'b0);
        repeat (4) begin @(posedge clock); #1; end
        check_reset_outs("rst_after");

        exp_start.push_back(2'b01);
        exp_start.push_back(2'b10);
        exp_start.push_back(2'b01);
        fork
            begin
                run_msg(0, 64'h100, -1, -1, -1, 1'b0);
                run_msg(0, 64'h300, -1, -1, -1, 1'b0);
            end
            run_msg(1, 64'h200, -1, -1, -1, 1'b0);
        join
        repeat (3) begin @(posedge clock); #1; end

        exp_start.push_back(2'b10);
        exp_start.push_back(2'b01);
        fork
            run_msg(1, 64'hB00, -1, 2, -1, 1'b0);
            run_msg(0, 64'hC00, -1, -1, -1, 1'b0);
        join

        repeat (10) begin @(posedge clock); #1; end
        check("sb_empty", 128'(sb.size()), '0);
        check("starts_empty", 128'(exp_start.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
